// File: rtl/load_use_stall_unit.sv
// Load-use hazard detector and pipeline enable arbiter: tracks in-flight destinations
// through EX/MEM/WB, stalls ID behind loads, and prioritises memory freeze and branch flush.
module load_use_stall_unit #(
    parameter int REG_W              = 3,
    parameter int LOAD_STALLS        = 1,
    parameter int ZERO_REG_HARDWIRED = 0,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             branch_taken_ex,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{v: 1'b0, rd: '0, wr: 1'b0, ld: 1'b0};

    shadow_t ex_q;
    shadow_t mem_q;
    shadow_t wb_q;
    shadow_t ex_next;

    logic hz_ex;
    logic hz_mem;
    logic hz;

    // A source only depends on an entry that is a valid load writing that register.
    function automatic logic src_match(input logic [REG_W-1:0] x, input shadow_t e);
        logic zero_exempt;
        zero_exempt = (ZERO_REG_HARDWIRED != 0) && (x == '0);
        return e.v && e.wr && e.ld && (x == e.rd) && !zero_exempt;
    endfunction

    always_comb begin
        hz_ex  = (id_uses_rs1 && src_match(id_rs1, ex_q)) ||
                 (id_uses_rs2 && src_match(id_rs2, ex_q));
        hz_mem = 1'b0;
        if (LOAD_STALLS == 2) begin
            hz_mem = (id_uses_rs1 && src_match(id_rs1, mem_q)) ||
                     (id_uses_rs2 && src_match(id_rs2, mem_q));
        end
        hz = id_valid && (hz_ex || hz_mem);
    end

    // Freeze beats flush beats stall; a flush squashes the dependent instruction anyway.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        stall_active = 1'b0;
        if (!mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken_ex) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_active = 1'b1;
        end
    end

    always_comb begin
        ex_next    = SHADOW_EMPTY;
        ex_next.rd = id_rd;
        ex_next.wr = id_regwrite;
        ex_next.ld = id_is_load;
        ex_next.v  = id_valid && !id_ex_bubble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SHADOW_EMPTY;
            mem_q <= SHADOW_EMPTY;
            wb_q  <= SHADOW_EMPTY;
        end else if (mem_ready) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_active && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // The WB entry is the retiring tail of the shadow; no hazard term reads it.
    logic wb_unused;
    assign wb_unused = ^wb_q;

endmodule

// File: tb/tb_load_use_stall_unit.sv
// Bench for load_use_stall_unit: four configurations share one stimulus stream and are
// checked against a timestamped in-flight-load model through an expected-value queue.
module tb_load_use_stall_unit;

  localparam int N  = 4;
  localparam int EW = 21;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [2:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       branch_taken_ex;
  logic       mem_ready;

  logic            pc_w  [N];
  logic            ifid_w[N];
  logic            bub   [N];
  logic            flush [N];
  logic            stall [N];
  logic [15:0]     cnt16 [N];
  logic [1:0]      cnt_small;

  // Per-instance configuration: 0 base, 1 two load stalls, 2 r0 hardwired, 3 2-bit counter.
  int cfg_ls   [N] = '{1, 2, 1, 1};
  int cfg_zr   [N] = '{0, 0, 1, 0};
  int cfg_cmax [N] = '{65535, 65535, 65535, 3};

  load_use_stall_unit #(.REG_W(3), .LOAD_STALLS(1), .ZERO_REG_HARDWIRED(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .branch_taken_ex(branch_taken_ex),
    .mem_ready(mem_ready), .pc_write(pc_w[0]), .if_id_write(ifid_w[0]),
    .id_ex_bubble(bub[0]), .if_id_flush(flush[0]), .stall_active(stall[0]), .stall_cnt(cnt16[0]));

  load_use_stall_unit #(.REG_W(3), .LOAD_STALLS(2), .ZERO_REG_HARDWIRED(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .branch_taken_ex(branch_taken_ex),
    .mem_ready(mem_ready), .pc_write(pc_w[1]), .if_id_write(ifid_w[1]),
    .id_ex_bubble(bub[1]), .if_id_flush(flush[1]), .stall_active(stall[1]), .stall_cnt(cnt16[1]));

  load_use_stall_unit #(.REG_W(3), .LOAD_STALLS(1), .ZERO_REG_HARDWIRED(1), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .branch_taken_ex(branch_taken_ex),
    .mem_ready(mem_ready), .pc_write(pc_w[2]), .if_id_write(ifid_w[2]),
    .id_ex_bubble(bub[2]), .if_id_flush(flush[2]), .stall_active(stall[2]), .stall_cnt(cnt16[2]));

  load_use_stall_unit #(.REG_W(3), .LOAD_STALLS(1), .ZERO_REG_HARDWIRED(0), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .branch_taken_ex(branch_taken_ex),
    .mem_ready(mem_ready), .pc_write(pc_w[3]), .if_id_write(ifid_w[3]),
    .id_ex_bubble(bub[3]), .if_id_flush(flush[3]), .stall_active(stall[3]), .stall_cnt(cnt_small));

  assign cnt16[3] = {14'd0, cnt_small};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: loads that entered EX, stamped with the advance count at entry
  typedef struct {
    int         inst;
    logic [2:0] rd;
    int         stamp;
  } load_rec_t;

  load_rec_t loads[$];
  int        adv[N];
  int        cnt[N];

  logic [N*EW-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  function automatic logic model_hazard(input int k);
    logic h;
    int   d;
    h = 1'b0;
    foreach (loads[i]) begin
      if (loads[i].inst == k) begin
        d = adv[k] - loads[i].stamp;
        if (d < cfg_ls[k]) begin
          if (id_uses_rs1 && id_rs1 == loads[i].rd && !(cfg_zr[k] != 0 && id_rs1 == 3'd0)) h = 1'b1;
          if (id_uses_rs2 && id_rs2 == loads[i].rd && !(cfg_zr[k] != 0 && id_rs2 == 3'd0)) h = 1'b1;
        end
      end
    end
    return id_valid && h;
  endfunction

  task automatic purge(input int k, input logic all);
    for (int i = loads.size() - 1; i >= 0; i--) begin
      if (loads[i].inst == k && (all || adv[k] - loads[i].stamp >= 3)) loads.delete(i);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic u1, input logic u2, input logic [2:0] rd,
                       input logic rw, input logic ld, input logic br, input logic mr,
                       input logic rst);
    logic [N*EW-1:0] e;
    logic [4:0]      ctl;
    logic            h;
    load_rec_t       r;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld; branch_taken_ex = br; mem_ready = mr;
    rst_n = rst;
    e = '0;
    for (int k = 0; k < N; k++) begin
      if (!rst) begin
        purge(k, 1'b1);
        cnt[k] = 0;
      end
      h = model_hazard(k);
      if (!mr)     ctl = 5'b00000;
      else if (br) ctl = 5'b11110;
      else if (h)  ctl = 5'b00101;
      else         ctl = 5'b11000;
      e[k*EW +: EW] = {ctl, 16'(cnt[k])};
      if (rst && mr) begin
        adv[k]++;
        if (ctl[0] && cnt[k] < cfg_cmax[k]) cnt[k]++;
        if (!br && !h && v && rw && ld) begin
          r.inst = k; r.rd = rd; r.stamp = adv[k];
          loads.push_back(r);
        end
        purge(k, 1'b0);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [N*EW-1:0] e;
    logic [4:0]      a_ctl;
    logic [4:0]      x_ctl;
    logic [15:0]     x_cnt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < N; k++) begin
        a_ctl = {pc_w[k], ifid_w[k], bub[k], flush[k], stall[k]};
        x_ctl = e[k*EW+16 +: 5];
        x_cnt = e[k*EW +: 16];
        n_cmp++;
        if (a_ctl !== x_ctl) begin
          n_fail++;
          $display("FAIL ctl inst%0d t=%0t got pc/ifid/bub/flush/stall=%b want %b", k, $time, a_ctl, x_ctl);
        end
        n_cmp++;
        if (cnt16[k] !== x_cnt) begin
          n_fail++;
          $display("FAIL stall_cnt inst%0d t=%0t got %0d want %0d", k, $time, cnt16[k], x_cnt);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int k = 0; k < N; k++) begin adv[k] = 0; cnt[k] = 0; end
    rst_n = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_is_load = 0; branch_taken_ex = 0; mem_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(5);
    // load r3 then dependent add (held in ID while stalled)
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 1);
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 1);
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 1);
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 1);
    idle(3);
    // ALU producer then use; load, independent, use
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1);
    drive(1, 3, 3, 1, 1, 5, 1, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 1);
    drive(1, 6, 7, 1, 1, 1, 1, 0, 0, 1, 1);
    drive(1, 1, 3, 0, 1, 2, 1, 0, 0, 1, 1);
    idle(3);
    // load r5, dependent use meets a taken branch
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 1, 1, 1);
    idle(3);
    // load r2, dependent use frozen for 3 cycles then stalls
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 0, 1);
    drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    idle(3);
    // load r0 then use of r0
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    drive(1, 0, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    idle(3);
    // randomized traffic with a narrow register range to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0, 1'b1);
    end
    idle(2);
    // reset asserted in the middle of a stall
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 1);
    drive(1, 6, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    drive(1, 6, 0, 1, 0, 4, 1, 0, 0, 1, 0);
    drive(1, 6, 0, 1, 0, 4, 1, 0, 0, 1, 1);
    idle(3);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
